branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage consumer of the ALU status flags. The ALU runs the branch compare as A-B with ALUControl=3'b001, and this block turns the resulting Zero/Negative/OverFlow/Carry flags into a branch decision.
- Computes the branch/JAL/JALR target and issues a registered one-cycle redirect to the fetch stage, plus flushes to the IF/ID and ID/EX registers.
- The pipeline is predict-not-taken; this block is the sole source of control-flow redirects.
- Keeps saturating branch/taken counters for performance debug.

Parameters:
- XLEN, 32, datapath width of PC, immediate and rs1.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid_e  input  1  EX stage holds a real instruction.
- stall_e  input  1  EX stage frozen this cycle.
- branch_e  input  1  conditional branch in EX.
- jump_e  input  1  unconditional jump (JAL or JALR) in EX.
- jalr_e  input  1  qualifies jump_e as JALR.
- funct3_e  input  3  branch condition code.
- zero  input  1  ALU Zero flag.
- negative  input  1  ALU Negative flag.
- overflow  input  1  ALU OverFlow flag.
- carry  input  1  ALU Carry flag.
- pc_e  input  XLEN  PC of the EX instruction.
- imm_e  input  XLEN  sign-extended immediate.
- rs1_e  input  XLEN  forwarded rs1 value, used by JALR.
- redirect_valid  output  1  load redirect_pc into the PC this cycle.
- redirect_pc  output  XLEN  target address.
- flush_d  output  1  clear the IF/ID register.
- flush_e  output  1  clear the ID/EX register.
- illegal_branch  output  1  one-cycle pulse for an unsupported funct3.
- branch_count  output  CNT_W  resolved conditional branches, saturating.
- taken_count  output  CNT_W  taken branches plus jumps, saturating.

Behaviour:
- Reset (rst=0, asynchronous): every output is 0, counters are 0, FSM goes to IDLE. Reset asserted mid-redirect aborts the redirect immediately.
- eval is the combinational condition valid_e & ~stall_e & state==IDLE.
- Condition decode, valid only when branch_e=1. Flags come from the A-B compare; Carry=1 means an unsigned borrow (A<B).
  - 000 BEQ: zero.
  - 001 BNE: ~zero.
  - 100 BLT: negative^overflow.
  - 101 BGE: ~(negative^overflow).
  - 110 BLTU: carry.
  - 111 BGEU: ~carry.
  - 010 and 011: not taken; illegal_branch pulses on the next cycle.
- Priority: jump_e over branch_e. When jump_e=1, taken is forced to 1 and funct3 is ignored.
- Target computation, modulo 2^XLEN (wraps silently):
  - Branch or JAL: pc_e+imm_e.
  - JALR: (rs1_e+imm_e) with bit0 forced to 0.
- FSM IDLE:
  - If eval & taken: register redirect_pc=target and go to REDIRECT.
  - Otherwise stay in IDLE with all pulse outputs 0.
- FSM REDIRECT, exactly one cycle:
  - redirect_valid=1, flush_d=1, flush_e=1.
  - valid_e, branch_e and jump_e are ignored because the EX instruction is wrong-path.
  - stall_e does not extend this state.
  - Always returns to IDLE next cycle.
- Latency: decision in cycle t, redirect and flushes in cycle t+1, new PC fetched at t+2. Back-to-back taken branches are impossible because the second one is squashed.
- Counters update at the clock edge that ends the eval cycle and saturate at all-ones (no wrap):
  - branch_count increments when eval & branch_e & ~jump_e, legal funct3 only.
  - taken_count increments when eval & taken.
- A stall with a branch in EX: no evaluation and no counting until stall_e drops. The instruction is then evaluated exactly once.
- valid_e=0: no action regardless of the other inputs.

Decomposition:
- Shared package holds:
  - funct3 constants: BEQ=3'b000, BNE=3'b001, BLT=3'b100, BGE=3'b101, BLTU=3'b110, BGEU=3'b111.
  - ALUControl SUB=3'b001.
  - FSM state encoding: IDLE=1'b0, REDIRECT=1'b1.
- One natural sub-module, branch_cond, is purely combinational: funct3 plus the four flags in, taken and illegal out. It is reused by the verification model.
- The FSM, target adder and counters stay in the top module.

Test Plan:
- BEQ, pc_e=0x100, imm_e=0x20, zero=1, valid_e=1 -> at t+1: redirect_valid=1, redirect_pc=0x120, flush_d=1, flush_e=1; branch_count=1, taken_count=1; all pulses low at t+2.
- BLT with negative=1, overflow=1 (not less), then BLTU with carry=1 at pc_e=0x40, imm_e=0xFFFFFFF0 -> first: no redirect, branch_count=1. Second: redirect_pc=0x30, taken_count=1.
- JALR with rs1_e=0x1003, imm_e=0x4, branch_e=1 and funct3=001 also asserted -> redirect_pc=0x1006 (bit0 cleared, jump wins); branch_count unchanged.
- Taken BNE at t, then another taken branch presented at t+1 -> only one redirect pulse; the second is ignored and not counted.
- Branch held with stall_e=1 for 3 cycles, then released -> no output during the stall, a single redirect one cycle after release, counters +1 only.
- funct3=010 branch -> illegal_branch pulses once, no redirect, counters unchanged. Separately, force taken_count to 0xFFFF and issue a JAL -> taken_count stays 0xFFFF. Separately, drop rst during REDIRECT -> all outputs go to 0 immediately.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the EX-stage branch resolver: branch condition codes,
// the ALU opcode the compare relies on, and the redirect FSM encoding.
package branch_resolve_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // The flags consumed here only mean anything when the ALU ran A-B.
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } stateT;

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// Combinational branch condition decode from the flags of an A-B compare.
// Carry set means an unsigned borrow, i.e. A < B unsigned.
module branch_cond
  import branch_resolve_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       negative,
  input  logic       overflow,
  input  logic       carry,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = negative ^ overflow;
      F3_BGE:  taken = ~(negative ^ overflow);
      F3_BLTU: taken = carry;
      F3_BGEU: taken = ~carry;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: decides taken, computes the target and issues
// a registered one-cycle redirect plus IF/ID and ID/EX flushes.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_e,
  input  logic             stall_e,
  input  logic             branch_e,
  input  logic             jump_e,
  input  logic             jalr_e,
  input  logic [2:0]       funct3_e,
  input  logic             zero,
  input  logic             negative,
  input  logic             overflow,
  input  logic             carry,
  input  logic [XLEN-1:0]  pc_e,
  input  logic [XLEN-1:0]  imm_e,
  input  logic [XLEN-1:0]  rs1_e,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_d,
  output logic             flush_e,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  stateT            state, stateNext;
  logic             condTaken, condIllegal;
  logic             eval, taken, countBranch, flagIllegal;
  logic [XLEN-1:0]  jalrSum, target;
  logic [XLEN-1:0]  redirectPcQ;
  logic             illegalQ;
  logic [CNT_W-1:0] branchCnt, takenCnt;

  branch_cond uCond (
    .funct3   (funct3_e),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow),
    .carry    (carry),
    .taken    (condTaken),
    .illegal  (condIllegal)
  );

  // The instruction in EX during REDIRECT is wrong-path, so eval excludes it.
  assign eval        = valid_e & ~stall_e & (state == IDLE);
  assign taken       = jump_e | (branch_e & condTaken);
  assign countBranch = eval & branch_e & ~jump_e & ~condIllegal;
  assign flagIllegal = eval & branch_e & ~jump_e & condIllegal;

  assign jalrSum = rs1_e + imm_e;
  assign target  = (jump_e & jalr_e) ? {jalrSum[XLEN-1:1], 1'b0} : (pc_e + imm_e);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (eval && taken) stateNext = REDIRECT;
      REDIRECT: stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Counters saturate at all-ones so a long debug run never wraps to a small value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirectPcQ <= '0;
      illegalQ    <= 1'b0;
      branchCnt   <= '0;
      takenCnt    <= '0;
    end else begin
      illegalQ <= flagIllegal;
      if (eval && taken) begin
        redirectPcQ <= target;
      end
      if (countBranch && (branchCnt != '1)) begin
        branchCnt <= branchCnt + 1'b1;
      end
      if (eval && taken && (takenCnt != '1)) begin
        takenCnt <= takenCnt + 1'b1;
      end
    end
  end

  assign redirect_valid = (state == REDIRECT);
  assign flush_d        = (state == REDIRECT);
  assign flush_e        = (state == REDIRECT);
  assign redirect_pc    = redirectPcQ;
  assign illegal_branch = illegalQ;
  assign branch_count   = branchCnt;
  assign taken_count    = takenCnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit; flags are derived from real A-B
// operands and a second narrow-counter instance exercises saturation.
module tb_branch_resolve_unit;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 16;
  localparam int SMALL_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_e, stall_e, branch_e, jump_e, jalr_e;
  logic [2:0]        funct3_e;
  logic              zero, negative, overflow, carry;
  logic [XLEN-1:0]   pc_e, imm_e, rs1_e;
  logic [XLEN-1:0]   opA, opB;

  logic              redirect_valid, flush_d, flush_e, illegal_branch;
  logic [XLEN-1:0]   redirect_pc;
  logic [CNT_W-1:0]  branch_count, taken_count;

  logic              sRedirectValid, sFlushD, sFlushE, sIllegal;
  logic [XLEN-1:0]   sRedirectPc;
  logic [SMALL_W-1:0] sBranchCount, sTakenCount;

  typedef struct {
    logic               rv;
    logic [XLEN-1:0]    pc;
    logic               ill;
    logic [CNT_W-1:0]   bc;
    logic [CNT_W-1:0]   tc;
    logic [SMALL_W-1:0] bcS;
    logic [SMALL_W-1:0] tcS;
  } expT;

  expT expQ[$];

  logic               mRedir;
  logic [XLEN-1:0]    mPc;
  logic [CNT_W-1:0]   mBc, mTc;
  logic [SMALL_W-1:0] mBcS, mTcS;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .stall_e(stall_e),
    .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e), .funct3_e(funct3_e),
    .zero(zero), .negative(negative), .overflow(overflow), .carry(carry),
    .pc_e(pc_e), .imm_e(imm_e), .rs1_e(rs1_e),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_d(flush_d), .flush_e(flush_e), .illegal_branch(illegal_branch),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(SMALL_W)) dutSmall (
    .clk(clk), .rst(rst), .valid_e(valid_e), .stall_e(stall_e),
    .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e), .funct3_e(funct3_e),
    .zero(zero), .negative(negative), .overflow(overflow), .carry(carry),
    .pc_e(pc_e), .imm_e(imm_e), .rs1_e(rs1_e),
    .redirect_valid(sRedirectValid), .redirect_pc(sRedirectPc),
    .flush_d(sFlushD), .flush_e(sFlushE), .illegal_branch(sIllegal),
    .branch_count(sBranchCount), .taken_count(sTakenCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decision straight from the operands, not from the flags.
  function automatic logic condModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic resetModel();
    mRedir = 1'b0; mPc = '0; mBc = '0; mTc = '0; mBcS = '0; mTcS = '0;
    expQ.delete();
  endtask

  task automatic stepCycle();
    expT e, got;
    logic ev, tk, legal, cb;
    logic [31:0] tgt, diff;
    diff     = opA - opB;
    zero     = (opA == opB);
    negative = diff[31];
    overflow = (opA[31] != opB[31]) && (diff[31] != opA[31]);
    carry    = (opA < opB);
    ev    = valid_e & ~stall_e & ~mRedir;
    tk    = jump_e | (branch_e & condModel(funct3_e, opA, opB));
    legal = (funct3_e != 3'b010) && (funct3_e != 3'b011);
    cb    = ev & branch_e & ~jump_e & legal;
    tgt   = (jump_e & jalr_e) ? ((rs1_e + imm_e) & 32'hFFFF_FFFE) : (pc_e + imm_e);
    e.rv  = ev & tk;
    e.pc  = e.rv ? tgt : mPc;
    e.ill = ev & branch_e & ~jump_e & ~legal;
    e.bc  = (cb && mBc != '1) ? mBc + 1'b1 : mBc;
    e.tc  = (e.rv && mTc != '1) ? mTc + 1'b1 : mTc;
    e.bcS = (cb && mBcS != '1) ? mBcS + 1'b1 : mBcS;
    e.tcS = (e.rv && mTcS != '1) ? mTcS + 1'b1 : mTcS;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = expQ.pop_front();
      checkOutput("redirect_valid", {31'd0, redirect_valid}, {31'd0, got.rv});
      checkOutput("flush_d", {31'd0, flush_d}, {31'd0, got.rv});
      checkOutput("flush_e", {31'd0, flush_e}, {31'd0, got.rv});
      checkOutput("illegal_branch", {31'd0, illegal_branch}, {31'd0, got.ill});
      checkOutput("branch_count", {16'd0, branch_count}, {16'd0, got.bc});
      checkOutput("taken_count", {16'd0, taken_count}, {16'd0, got.tc});
      checkOutput("small_branch_count", {30'd0, sBranchCount}, {30'd0, got.bcS});
      checkOutput("small_taken_count", {30'd0, sTakenCount}, {30'd0, got.tcS});
      if (got.rv) checkOutput("redirect_pc", redirect_pc, got.pc);
      mRedir = got.rv; mPc = got.pc; mBc = got.bc; mTc = got.tc; mBcS = got.bcS; mTcS = got.tcS;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic st, input logic br, input logic jp,
                               input logic jr, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [31:0] rs1);
    valid_e = v; stall_e = st; branch_e = br; jump_e = jp; jalr_e = jr; funct3_e = f3;
    opA = a; opB = b; pc_e = pc; imm_e = imm; rs1_e = rs1;
    stepCycle();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rv"}, {31'd0, redirect_valid}, 32'd0);
    checkOutput({tag, "_fd"}, {31'd0, flush_d}, 32'd0);
    checkOutput({tag, "_fe"}, {31'd0, flush_e}, 32'd0);
    checkOutput({tag, "_ill"}, {31'd0, illegal_branch}, 32'd0);
    checkOutput({tag, "_pc"}, redirect_pc, 32'd0);
    checkOutput({tag, "_bc"}, {16'd0, branch_count}, 32'd0);
    checkOutput({tag, "_tc"}, {16'd0, taken_count}, 32'd0);
    checkOutput({tag, "_small_tc"}, {30'd0, sTakenCount}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    int kind;
    rst = 1'b1;
    valid_e = 0; stall_e = 0; branch_e = 0; jump_e = 0; jalr_e = 0; funct3_e = '0;
    zero = 0; negative = 0; overflow = 0; carry = 0;
    pc_e = '0; imm_e = '0; rs1_e = '0; opA = '0; opB = '0;
    resetModel();
    #1 rst = 1'b0;
    #10;
    checkAllZero("reset");
    rst = 1'b1;

    // BEQ taken, then pulses must drop
    applyStimulus(1, 0, 1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 32'd0);
    idleCycle();
    idleCycle();
    // BLT not-less (neg=1, ovf=1), then BLTU with borrow and negative immediate
    applyStimulus(1, 0, 1, 0, 0, 3'b100, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h40, 32'd8, 32'd0);
    applyStimulus(1, 0, 1, 0, 0, 3'b110, 32'd1, 32'd2, 32'h40, 32'hFFFF_FFF0, 32'd0);
    idleCycle();
    // JALR wins over a simultaneous taken BNE
    applyStimulus(1, 0, 1, 1, 1, 3'b001, 32'd1, 32'd2, 32'h200, 32'h4, 32'h1003);
    idleCycle();
    // Taken BNE followed immediately by another taken branch (squashed)
    applyStimulus(1, 0, 1, 0, 0, 3'b001, 32'd3, 32'd4, 32'h300, 32'h10, 32'd0);
    applyStimulus(1, 0, 1, 0, 0, 3'b000, 32'd7, 32'd7, 32'h304, 32'h40, 32'd0);
    idleCycle();
    // Stalled BGEU held three cycles, then released
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 1, 0, 0, 3'b111, 32'd9, 32'd2, 32'h400, 32'h80, 32'd0);
    applyStimulus(1, 0, 1, 0, 0, 3'b111, 32'd9, 32'd2, 32'h400, 32'h80, 32'd0);
    idleCycle();
    idleCycle();
    // Illegal funct3 codes and an invalid slot
    applyStimulus(1, 0, 1, 0, 0, 3'b010, 32'd1, 32'd1, 32'h500, 32'h8, 32'd0);
    applyStimulus(1, 0, 1, 0, 0, 3'b011, 32'd1, 32'd1, 32'h500, 32'h8, 32'd0);
    applyStimulus(0, 0, 1, 1, 0, 3'b000, 32'd1, 32'd1, 32'h600, 32'h8, 32'd0);
    idleCycle();
    // Enough JALs and BGEs to pin the narrow counters at all-ones
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h1000 + i, 32'h100, 32'd0);
      applyStimulus(1, 0, 1, 0, 0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h2000, 32'h8, 32'd0);
    end
    // Wrap-around target
    applyStimulus(1, 0, 0, 1, 0, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h20, 32'd0);
    idleCycle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      kind = $urandom_range(0, 3);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                    kind == 1 || kind == 2 || $urandom_range(0, 7) == 0, kind == 0,
                    $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), a, b,
                    $urandom(), $urandom(), $urandom());
    end

    // Asynchronous reset in the middle of a redirect
    applyStimulus(1, 0, 0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h700, 32'h10, 32'd0);
    checkOutput("pre_reset_rv", {31'd0, redirect_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkAllZero("async_reset");
    resetModel();
    #2 rst = 1'b1;
    applyStimulus(1, 0, 1, 0, 0, 3'b000, 32'd1, 32'd1, 32'h800, 32'h4, 32'd0);
    idleCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
